// File: rtl/target_placement_ctrl.sv
// Snake-game target placement sequencer: samples RNG addresses, queries the snake-body store, commits a free cell.
// Optional macro TARGET_FOLD_EN folds out-of-range candidates back into the field instead of rejecting them.
module target_placement_ctrl #(
  parameter int          X_MAX         = 160,
  parameter int          Y_MAX         = 120,
  parameter int          MAX_TRIES     = 16,
  parameter logic [14:0] FALLBACK_ADDR = {8'd80, 7'd60},
  parameter int          CNT_W         = 8
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic [1:0]       MSM_State,
  input  logic             REACHED_TARGET,
  input  logic [14:0]      RAND_ADDR,
  output logic             CHK_REQ,
  output logic [14:0]      CHK_ADDR,
  input  logic             CHK_ACK,
  input  logic             CHK_HIT,
  output logic [14:0]      TARGET_ADDR,
  output logic             TARGET_VALID,
  output logic             NEW_TARGET,
  output logic [CNT_W-1:0] TARGET_COUNT,
  output logic             PLACE_ERR
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SAMPLE,
    ST_CHECK,
    ST_COMMIT,
    ST_HOLD
  } state_t;

  localparam logic [7:0] X_LIM     = X_MAX[7:0];
  localparam logic [6:0] Y_LIM     = Y_MAX[6:0];
  localparam logic [7:0] TRIES_LIM = MAX_TRIES[7:0];
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [14:0]      cand_q, cand_d;
  logic [7:0]       try_cnt_q, try_cnt_d;
  logic             abort_q, abort_d;
  logic             chk_req_q, chk_req_d;
  logic [14:0]      chk_addr_q, chk_addr_d;
  logic [14:0]      target_addr_q, target_addr_d;
  logic             target_valid_q, target_valid_d;
  logic             new_target_q, new_target_d;
  logic [CNT_W-1:0] target_count_q, target_count_d;
  logic             place_err_q, place_err_d;

  logic [7:0]  rand_x;
  logic [6:0]  rand_y;
  logic [14:0] samp_addr;
  logic        samp_ok;
  logic [7:0]  try_next;
  logic        msm_idle;
  logic        msm_play;

  assign rand_x   = RAND_ADDR[14:7];
  assign rand_y   = RAND_ADDR[6:0];
  assign try_next = try_cnt_q + 8'd1;
  assign msm_idle = (MSM_State == 2'b00);
  assign msm_play = (MSM_State == 2'b01);

`ifdef TARGET_FOLD_EN
  // A single subtraction suffices: the largest raw coordinate minus the limit is always back in range.
  logic [7:0] fold_x;
  logic [6:0] fold_y;
  always_comb begin
    fold_x    = (rand_x >= X_LIM) ? (rand_x - X_LIM) : rand_x;
    fold_y    = (rand_y >= Y_LIM) ? (rand_y - Y_LIM) : rand_y;
    samp_addr = {fold_x, fold_y};
    samp_ok   = 1'b1;
  end
`else
  always_comb begin
    samp_addr = RAND_ADDR;
    samp_ok   = (rand_x < X_LIM) && (rand_y < Y_LIM);
  end
`endif

  always_comb begin
    state_d        = state_q;
    cand_d         = cand_q;
    try_cnt_d      = try_cnt_q;
    abort_d        = abort_q;
    chk_req_d      = chk_req_q;
    chk_addr_d     = chk_addr_q;
    target_addr_d  = target_addr_q;
    target_valid_d = target_valid_q;
    new_target_d   = 1'b0;
    target_count_d = target_count_q;
    place_err_d    = place_err_q;

    case (state_q)
      ST_IDLE: begin
        target_valid_d = 1'b0;
        target_count_d = '0;
        place_err_d    = 1'b0;
        try_cnt_d      = 8'd0;
        chk_req_d      = 1'b0;
        abort_d        = 1'b0;
        if (msm_play) state_d = ST_SAMPLE;
      end

      ST_SAMPLE: begin
        if (msm_idle) begin
          state_d = ST_IDLE;
        end else begin
          cand_d    = samp_addr;
          try_cnt_d = try_next;
          if (samp_ok) begin
            state_d    = ST_CHECK;
            chk_req_d  = 1'b1;
            chk_addr_d = samp_addr;
          end else if (try_next >= TRIES_LIM) begin
            cand_d      = FALLBACK_ADDR;
            place_err_d = 1'b1;
            state_d     = ST_COMMIT;
          end
        end
      end

      // An abort seen mid-handshake is remembered so the query still completes cleanly.
      ST_CHECK: begin
        if (msm_idle) abort_d = 1'b1;
        if (CHK_ACK) begin
          chk_req_d = 1'b0;
          abort_d   = 1'b0;
          if (abort_q || msm_idle) begin
            state_d = ST_IDLE;
          end else if (!CHK_HIT) begin
            state_d = ST_COMMIT;
          end else if (try_cnt_q >= TRIES_LIM) begin
            cand_d      = FALLBACK_ADDR;
            place_err_d = 1'b1;
            state_d     = ST_COMMIT;
          end else begin
            state_d = ST_SAMPLE;
          end
        end
      end

      ST_COMMIT: begin
        if (msm_idle) begin
          state_d = ST_IDLE;
        end else begin
          target_addr_d  = cand_q;
          target_valid_d = 1'b1;
          new_target_d   = 1'b1;
          if (target_count_q != {CNT_W{1'b1}}) target_count_d = target_count_q + CNT_ONE;
          try_cnt_d      = 8'd0;
          state_d        = ST_HOLD;
        end
      end

      ST_HOLD: begin
        if (msm_idle) begin
          state_d = ST_IDLE;
        end else if (msm_play && REACHED_TARGET) begin
          target_valid_d = 1'b0;
          state_d        = ST_SAMPLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q        <= ST_IDLE;
      cand_q         <= '0;
      try_cnt_q      <= '0;
      abort_q        <= 1'b0;
      chk_req_q      <= 1'b0;
      chk_addr_q     <= '0;
      target_addr_q  <= '0;
      target_valid_q <= 1'b0;
      new_target_q   <= 1'b0;
      target_count_q <= '0;
      place_err_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      cand_q         <= cand_d;
      try_cnt_q      <= try_cnt_d;
      abort_q        <= abort_d;
      chk_req_q      <= chk_req_d;
      chk_addr_q     <= chk_addr_d;
      target_addr_q  <= target_addr_d;
      target_valid_q <= target_valid_d;
      new_target_q   <= new_target_d;
      target_count_q <= target_count_d;
      place_err_q    <= place_err_d;
    end
  end

  assign CHK_REQ      = chk_req_q;
  assign CHK_ADDR     = chk_addr_q;
  assign TARGET_ADDR  = target_addr_q;
  assign TARGET_VALID = target_valid_q;
  assign NEW_TARGET   = new_target_q;
  assign TARGET_COUNT = target_count_q;
  assign PLACE_ERR    = place_err_q;

endmodule

// File: tb/tb_target_placement_ctrl.sv
// Scoreboard bench for target_placement_ctrl: expected commits are queued at stimulus time and popped on NEW_TARGET.
module tb_target_placement_ctrl;

  logic        CLK;
  logic        RESETN;
  logic [1:0]  MSM_State;
  logic        REACHED_TARGET;
  logic [14:0] RAND_ADDR;
  logic        CHK_REQ;
  logic [14:0] CHK_ADDR;
  logic        CHK_ACK;
  logic        CHK_HIT;
  logic [14:0] TARGET_ADDR;
  logic        TARGET_VALID;
  logic        NEW_TARGET;
  logic [7:0]  TARGET_COUNT;
  logic        PLACE_ERR;

  logic ack_auto;
  logic ack_man;
  logic hit_val;

  typedef struct {
    logic [14:0] addr;
    logic [7:0]  cnt;
  } exp_t;

  exp_t        exp_q[$];
  logic [14:0] query_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  target_placement_ctrl dut (
    .CLK            (CLK),
    .RESETN         (RESETN),
    .MSM_State      (MSM_State),
    .REACHED_TARGET (REACHED_TARGET),
    .RAND_ADDR      (RAND_ADDR),
    .CHK_REQ        (CHK_REQ),
    .CHK_ADDR       (CHK_ADDR),
    .CHK_ACK        (CHK_ACK),
    .CHK_HIT        (CHK_HIT),
    .TARGET_ADDR    (TARGET_ADDR),
    .TARGET_VALID   (TARGET_VALID),
    .NEW_TARGET     (NEW_TARGET),
    .TARGET_COUNT   (TARGET_COUNT),
    .PLACE_ERR      (PLACE_ERR)
  );

  // Body-store responder: either acks in the first request cycle or on explicit command.
  assign CHK_ACK = ack_auto ? CHK_REQ : ack_man;
  assign CHK_HIT = hit_val;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_exp(input logic [14:0] a, input logic [7:0] c);
    exp_t e;
    e.addr = a;
    e.cnt  = c;
    exp_q.push_back(e);
  endtask

  task automatic wait_commit(input int max_cyc);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge CLK);
      if (NEW_TARGET) begin
        seen = 1'b1;
        break;
      end
    end
    check_val("commit_seen", {31'd0, seen}, 32'd1);
  endtask

  always @(negedge CLK) begin
    if (RESETN && CHK_REQ && CHK_ACK) query_q.push_back(CHK_ADDR);
  end

  always @(negedge CLK) begin
    if (RESETN && NEW_TARGET) begin
      if (exp_q.size() == 0) begin
        check_val("spurious_new_target", {31'd0, NEW_TARGET}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check_val("sb_target_addr", {17'd0, TARGET_ADDR}, {17'd0, e.addr});
        check_val("sb_target_count", {24'd0, TARGET_COUNT}, {24'd0, e.cnt});
        check_val("sb_target_valid", {31'd0, TARGET_VALID}, 32'd1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [14:0] exp_a;
    int          n;
    logic        saw_req;

    RESETN = 1'b0; MSM_State = 2'b00; REACHED_TARGET = 1'b0; RAND_ADDR = '0;
    ack_auto = 1'b0; ack_man = 1'b0; hit_val = 1'b0;
    repeat (2) @(negedge CLK);
    check_val("rst_chk_req", {31'd0, CHK_REQ}, 32'd0);
    check_val("rst_chk_addr", {17'd0, CHK_ADDR}, 32'd0);
    check_val("rst_target_addr", {17'd0, TARGET_ADDR}, 32'd0);
    check_val("rst_target_valid", {31'd0, TARGET_VALID}, 32'd0);
    check_val("rst_new_target", {31'd0, NEW_TARGET}, 32'd0);
    check_val("rst_target_count", {24'd0, TARGET_COUNT}, 32'd0);
    check_val("rst_place_err", {31'd0, PLACE_ERR}, 32'd0);
    tick();
    RESETN = 1'b1;

    // First placement, ack in the request cycle
    tick();
    MSM_State = 2'b01; RAND_ADDR = {8'd10, 7'd20}; ack_auto = 1'b1;
    push_exp(15'h0514, 8'd1);
    wait_commit(20);
    check_val("t1_query_addr", (query_q.size() > 0) ? {17'd0, query_q[0]} : 32'hFFFF_FFFF, 32'h0514);
    @(negedge CLK);
    check_val("t1_new_target_one_cycle", {31'd0, NEW_TARGET}, 32'd0);

    // Replacement latency from REACHED_TARGET
    tick();
    REACHED_TARGET = 1'b1; RAND_ADDR = {8'd3, 7'd4};
    push_exp(15'h0184, 8'd2);
    tick();
    REACHED_TARGET = 1'b0;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge CLK);
      n++;
      @(negedge CLK);
      if (NEW_TARGET) break;
    end
    check_val("t2_latency_edges", n, 32'd3);

    // Out-of-range rejection (or fold)
    tick();
    query_q.delete();
`ifdef TARGET_FOLD_EN
    exp_a = 15'h1405;
`else
    exp_a = 15'h0285;
`endif
    push_exp(exp_a, 8'd3);
    REACHED_TARGET = 1'b1; RAND_ADDR = {8'd200, 7'd5};
    tick();
    REACHED_TARGET = 1'b0;
    tick();
    tick();
    RAND_ADDR = {8'd5, 7'd5};
    wait_commit(20);
    check_val("t3_query_count", query_q.size(), 32'd1);
    check_val("t3_first_query", (query_q.size() > 0) ? {17'd0, query_q[0]} : 32'hFFFF_FFFF, {17'd0, exp_a});

    // Every query hits: fallback after MAX_TRIES
    tick();
    query_q.delete();
    hit_val = 1'b1; RAND_ADDR = {8'd10, 7'd20}; REACHED_TARGET = 1'b1;
    push_exp(15'h283C, 8'd4);
    tick();
    REACHED_TARGET = 1'b0;
    wait_commit(100);
    check_val("t4_place_err", {31'd0, PLACE_ERR}, 32'd1);
    check_val("t4_query_count", query_q.size(), 32'd16);
    tick();
    hit_val = 1'b0; MSM_State = 2'b00;
    repeat (3) tick();
    @(negedge CLK);
    check_val("t4_idle_place_err", {31'd0, PLACE_ERR}, 32'd0);
    check_val("t4_idle_valid", {31'd0, TARGET_VALID}, 32'd0);
    check_val("t4_idle_count", {24'd0, TARGET_COUNT}, 32'd0);

    // Delayed ack with abort raised mid-wait
    tick();
    MSM_State = 2'b01; RAND_ADDR = {8'd10, 7'd20}; ack_auto = 1'b1;
    push_exp(15'h0514, 8'd1);
    wait_commit(20);
    tick();
    ack_auto = 1'b0; ack_man = 1'b0; REACHED_TARGET = 1'b1; RAND_ADDR = {8'd3, 7'd4};
    tick();
    REACHED_TARGET = 1'b0;
    saw_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (CHK_REQ) begin
        saw_req = 1'b1;
        break;
      end
    end
    check_val("t5_req_seen", {31'd0, saw_req}, 32'd1);
    check_val("t5_chk_addr", {17'd0, CHK_ADDR}, 32'h0184);
    for (int i = 0; i < 5; i++) begin
      tick();
      RAND_ADDR = 15'(RAND_ADDR + 15'd129);
      if (i == 2) MSM_State = 2'b00;
      @(negedge CLK);
      check_val("t5_req_held", {31'd0, CHK_REQ}, 32'd1);
      check_val("t5_addr_stable", {17'd0, CHK_ADDR}, 32'h0184);
    end
    tick();
    ack_man = 1'b1;
    tick();
    ack_man = 1'b0;
    @(negedge CLK);
    check_val("t5_req_dropped", {31'd0, CHK_REQ}, 32'd0);
    repeat (3) tick();
    @(negedge CLK);
    check_val("t5_abort_valid", {31'd0, TARGET_VALID}, 32'd0);
    check_val("t5_abort_count", {24'd0, TARGET_COUNT}, 32'd0);

    // LOSE freezes HOLD
    tick();
    MSM_State = 2'b01; RAND_ADDR = {8'd10, 7'd20}; ack_auto = 1'b1;
    push_exp(15'h0514, 8'd1);
    wait_commit(20);
    tick();
    query_q.delete();
    MSM_State = 2'b11; REACHED_TARGET = 1'b1; RAND_ADDR = {8'd3, 7'd4};
    repeat (10) tick();
    @(negedge CLK);
    check_val("t6_addr_frozen", {17'd0, TARGET_ADDR}, 32'h0514);
    check_val("t6_valid_held", {31'd0, TARGET_VALID}, 32'd1);
    check_val("t6_no_query", query_q.size(), 32'd0);
    check_val("t6_no_req", {31'd0, CHK_REQ}, 32'd0);
    REACHED_TARGET = 1'b0;

    check_val("sb_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/target_placement_ctrl.md
Name: target_placement_ctrl

Overview:
- Sequencer that places each snake-game target.
- Takes a free-running random address from the target RNG and rejects candidates outside the 160x120 reduced-resolution field.
- Asks the snake-body store whether the candidate is occupied, over a req/ack handshake.
- Commits a free cell as the live target and counts targets issued. Sits between the master state machine, the RNG and the VGA/snake-body logic.

Parameters:
- X_MAX, 160, exclusive upper bound of the X field (address bits [14:7]).
- Y_MAX, 120, exclusive upper bound of the Y field (address bits [6:0]).
- MAX_TRIES, 16, candidates tried before fallback; range 2..255.
- FALLBACK_ADDR, {8'd80,7'd60}, target committed when tries run out.
- CNT_W, 8, width of TARGET_COUNT.

Ports:
- CLK  in  1  system clock
- RESETN  in  1  asynchronous active-low reset
- MSM_State  in  2  00 IDLE, 01 PLAY, 10 WIN, 11 LOSE
- REACHED_TARGET  in  1  level; snake head is on the target
- RAND_ADDR  in  15  {X[7:0],Y[6:0]} from RNG; changes every cycle
- CHK_REQ  out  1  occupancy query request
- CHK_ADDR  out  15  address being queried; stable while CHK_REQ=1
- CHK_ACK  in  1  query done; may be high in the first CHK_REQ cycle
- CHK_HIT  in  1  valid with CHK_ACK; 1 = cell occupied by snake
- TARGET_ADDR  out  15  committed target
- TARGET_VALID  out  1  TARGET_ADDR is live
- NEW_TARGET  out  1  one-cycle pulse on each commit
- TARGET_COUNT  out  CNT_W  targets committed since IDLE, saturating
- PLACE_ERR  out  1  sticky; fallback was used

Behaviour:
- Reset (RESETN=0, async): state IDLE. All outputs are 0, try_cnt=0, cand=0.
- All outputs are registered.
- States: IDLE, SAMPLE, CHECK, COMMIT, HOLD.
- IDLE:
  - TARGET_VALID=0; TARGET_COUNT and PLACE_ERR cleared.
  - Goes to SAMPLE when MSM_State==01.
- SAMPLE:
  - cand<=RAND_ADDR; try_cnt++.
  - If X<X_MAX and Y<Y_MAX, go to CHECK with CHK_REQ<=1 and CHK_ADDR<=RAND_ADDR. Otherwise stay in SAMPLE.
- CHECK:
  - Hold CHK_REQ and CHK_ADDR until CHK_ACK is sampled high, then CHK_REQ<=0 on that edge.
  - CHK_HIT=0: go to COMMIT with cand.
  - CHK_HIT=1: go back to SAMPLE.
- Exhaustion: when try_cnt reaches MAX_TRIES without a free cell, cand<=FALLBACK_ADDR, PLACE_ERR<=1, go to COMMIT. The fallback is not checked.
- COMMIT:
  - TARGET_ADDR<=cand, TARGET_VALID<=1, NEW_TARGET<=1 for one cycle.
  - TARGET_COUNT++ (holds at all-ones).
  - try_cnt<=0; go to HOLD.
- HOLD:
  - REACHED_TARGET=1 with MSM_State==01: TARGET_VALID<=0, go to SAMPLE.
  - MSM_State 10 or 11: freeze; REACHED_TARGET is ignored.
- Abort: MSM_State==00 sends any state to IDLE on the next edge, except CHECK. CHECK completes its handshake first; the result is discarded and the block goes to IDLE.
- Priority: if MSM_State==00 and REACHED_TARGET are high in the same cycle, IDLE wins.
- REACHED_TARGET outside HOLD is ignored. It is a level: if still high after the next commit, one more placement starts.
- Latency with CHK_ACK in the first request cycle:
  - edge0 samples REACHED_TARGET.
  - edge1 raises CHK_REQ.
  - edge2 samples CHK_ACK.
  - edge3 raises NEW_TARGET and TARGET_VALID with the new TARGET_ADDR.

Optional Feature:
- Macro: TARGET_FOLD_EN.
- Defined: out-of-range candidates are folded, not rejected: X>=X_MAX becomes X-X_MAX, Y>=Y_MAX becomes Y-Y_MAX. Every sample then proceeds to CHECK, and only CHK_HIT rejects consume tries.
- Undefined: out-of-range candidates are rejected as above.

Test Plan:
- Reset then MSM_State=01, RAND_ADDR={8'd10,7'd20}, ACK in the same cycle as REQ with HIT=0 -> CHK_ADDR=0x0514; TARGET_ADDR=0x0514, VALID=1, NEW_TARGET one cycle, COUNT=1.
- In HOLD, pulse REACHED_TARGET with RAND_ADDR={8'd3,7'd4} -> NEW_TARGET exactly 3 edges later, TARGET_ADDR=0x0184, COUNT=2.
- RAND_ADDR={8'd200,7'd5} for 2 cycles then {8'd5,7'd5} -> no CHK_REQ for 200, query 0x0285. With TARGET_FOLD_EN, the first query is {8'd40,7'd5}=0x1405.
- CHK_HIT=1 on every query -> after 16 tries TARGET_ADDR=0x283C, PLACE_ERR=1; MSM_State=00 clears PLACE_ERR.
- CHK_ACK delayed 5 cycles with MSM_State=00 raised mid-wait -> CHK_ADDR stable until ACK, then IDLE, VALID=0, COUNT=0, no NEW_TARGET.
- MSM_State=11 in HOLD with REACHED_TARGET=1 -> TARGET_ADDR unchanged, no CHK_REQ.
